// File: rtl/fetch_unit.sv
// Program counter and instruction register stage in front of a registered-read instruction memory.
// Optional FETCH_STATS_EN adds saturating bubble_count / fetch_count outputs.
module fetch_unit #(
  parameter int              BITS     = 8,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [BITS-1:0] pc,
  input  logic [BITS-1:0] instruction,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [BITS-1:0] branch_target,
  input  logic            halt_req,
  output logic [BITS-1:0] ir,
  output logic [BITS-1:0] ir_pc,
  output logic            ir_valid,
`ifdef FETCH_STATS_EN
  output logic [BITS-1:0] bubble_count,
  output logic [BITS-1:0] fetch_count,
`endif
  output logic            halted
);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] pc_q, pc_d;
  logic [BITS-1:0] ir_q, ir_d;
  logic [BITS-1:0] ir_pc_q, ir_pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic            halt_now;
  logic            load_now;
  logic            bubble_now;

  // A halt request freezes the PC, which is what drops a same-cycle branch.
  assign halt_now = (state_q != S_HALTED) && halt_req;

  always_comb begin
    pc_d = pc_q;
    if (!rst_n) begin
      pc_d = RESET_PC;
    end else if (state_q == S_HALTED || halt_req) begin
      pc_d = pc_q;
    end else if (branch_taken) begin
      pc_d = branch_target;
    end else if (stall || state_q == S_FILL) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + BITS'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    load_now   = 1'b0;
    bubble_now = 1'b0;
    if (halt_now) begin
      state_d    = S_HALTED;
      ir_valid_d = 1'b0;
      bubble_now = (state_q == S_RUN);
    end else begin
      case (state_q)
        S_FILL: state_d = S_RUN;
        S_RUN: begin
          if (branch_taken) begin
            ir_valid_d = 1'b0;
            bubble_now = 1'b1;
          end else if (stall) begin
            bubble_now = 1'b1;
          end else begin
            ir_d       = instruction;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            load_now   = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign pc       = pc_d;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = (state_q == S_HALTED);

`ifdef FETCH_STATS_EN
  logic [BITS-1:0] bubble_count_q, bubble_count_d;
  logic [BITS-1:0] fetch_count_q, fetch_count_d;

  always_comb begin
    bubble_count_d = bubble_count_q;
    fetch_count_d  = fetch_count_q;
    if (bubble_now && bubble_count_q != '1) bubble_count_d = bubble_count_q + BITS'(1);
    if (load_now && fetch_count_q != '1)    fetch_count_d  = fetch_count_q + BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_count_q <= '0;
      fetch_count_q  <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  assign bubble_count = bubble_count_q;
  assign fetch_count  = fetch_count_q;
`else
  logic unused_stats;
  assign unused_stats = load_now ^ bubble_now;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a registered-read ROM holding mem[i] = i.
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] pc;
  logic [7:0] instruction;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       halt_req;
  logic [7:0] ir;
  logic [7:0] ir_pc;
  logic       ir_valid;
  logic       halted;
`ifdef FETCH_STATS_EN
  logic [7:0] bubble_count;
  logic [7:0] fetch_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int n_edges  = 0;
  int n_loads  = 0;
  logic [7:0] rom [256];

  fetch_unit #(.BITS(8), .RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .instruction   (instruction),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
`ifdef FETCH_STATS_EN
    .bubble_count  (bubble_count),
    .fetch_count   (fetch_count),
`endif
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
  end

  always @(posedge clk) instruction <= rom[pc];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n_edges++;
    $display("edge %0d: rst_n=%b stall=%b br=%b tgt=%h halt=%b | pc=%h ir=%h ir_pc=%h v=%b halted=%b",
             n_edges, rst_n, stall, branch_taken, branch_target, halt_req,
             pc, ir, ir_pc, ir_valid, halted);
  endtask

  task automatic expect_load(input string tag, input logic [7:0] addr);
    check_eq({tag, "_ir"}, 32'(ir), 32'(addr));
    check_eq({tag, "_ir_pc"}, 32'(ir_pc), 32'(addr));
    check_eq({tag, "_valid"}, 32'(ir_valid), 32'd1);
    n_loads++;
  endtask

  initial begin
    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    halt_req      = 1'b0;

    repeat (3) step();
    check_eq("rst_ir",     32'(ir),       32'h00);
    check_eq("rst_ir_pc",  32'(ir_pc),    32'h00);
    check_eq("rst_valid",  32'(ir_valid), 32'd0);
    check_eq("rst_halted", 32'(halted),   32'd0);
    check_eq("rst_pc",     32'(pc),       32'h00);

    rst_n = 1'b1;
    step();
    check_eq("fill_valid", 32'(ir_valid), 32'd0);
    check_eq("fill_pc",    32'(pc),       32'h01);

    for (int a = 8'h00; a <= 8'h10; a++) begin
      step();
      expect_load("seq", 8'(a));
    end

    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("stall_ir",    32'(ir),       32'h10);
      check_eq("stall_ir_pc", 32'(ir_pc),    32'h10);
      check_eq("stall_valid", 32'(ir_valid), 32'd1);
    end
    stall = 1'b0;
    for (int a = 8'h11; a <= 8'h20; a++) begin
      step();
      expect_load("post_stall", 8'(a));
    end

    branch_taken  = 1'b1;
    branch_target = 8'h80;
    step();
    check_eq("br_bubble", 32'(ir_valid), 32'd0);
    branch_taken = 1'b0;
    step();
    expect_load("br_target", 8'h80);
    step();
    expect_load("br_next", 8'h81);

    for (int a = 8'h82; a <= 8'hFF; a++) begin
      step();
      expect_load("seq_hi", 8'(a));
    end
    step();
    expect_load("wrap", 8'h00);
    step();
    expect_load("wrap_next", 8'h01);

    branch_taken  = 1'b1;
    stall         = 1'b1;
    branch_target = 8'h40;
    step();
    check_eq("brst_flush", 32'(ir_valid), 32'd0);
    branch_taken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check_eq("brst_hold", 32'(ir_valid), 32'd0);
    end
    stall = 1'b0;
    step();
    expect_load("brst_target", 8'h40);
    step();
    expect_load("brst_next", 8'h41);

    halt_req      = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 8'h90;
    step();
    check_eq("halt_halted", 32'(halted),   32'd1);
    check_eq("halt_valid",  32'(ir_valid), 32'd0);
    check_eq("halt_pc",     32'(pc),       32'h42);
    halt_req      = 1'b0;
    branch_target = 8'h33;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("hold_halted", 32'(halted),   32'd1);
      check_eq("hold_pc",     32'(pc),       32'h42);
      check_eq("hold_valid",  32'(ir_valid), 32'd0);
      check_eq("hold_ir",     32'(ir),       32'h41);
    end
`ifdef FETCH_STATS_EN
    check_eq("stat_fetch",  32'(fetch_count),  32'(n_loads));
    check_eq("stat_bubble", 32'(bubble_count), 32'd8);
`endif

    branch_taken = 1'b0;
    rst_n        = 1'b0;
    step();
    check_eq("rerst_halted", 32'(halted),   32'd0);
    check_eq("rerst_valid",  32'(ir_valid), 32'd0);
    check_eq("rerst_ir",     32'(ir),       32'h00);
    check_eq("rerst_pc",     32'(pc),       32'h00);
`ifdef FETCH_STATS_EN
    check_eq("rerst_fetch",  32'(fetch_count),  32'd0);
    check_eq("rerst_bubble", 32'(bubble_count), 32'd0);
`endif
    rst_n = 1'b1;
    step();
    check_eq("restart_fill", 32'(ir_valid), 32'd0);
    step();
    expect_load("restart0", 8'h00);
    step();
    expect_load("restart1", 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
